miso_drain_packer: RTL and testbench
====================================

Name: miso_drain_packer

Overview:
- Sits directly downstream of the router's multi-input/single-output byte FIFO.
- Pops one byte per cycle from that FIFO and packs PACK_LENGTH consecutive bytes into one wide word.
- Presents each word to the PE-array feeder with a valid/ready handshake.
- A flush request drains the FIFO, then emits any trailing partial word with a byte mask.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- PACK_LENGTH, 4, bytes per packed output word (must be ≥2).
- IDX_WIDTH, $clog2(PACK_LENGTH), width of the lane index counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_clear  in  1  synchronous soft clear; same effect as i_rst.
- i_fifo_data  in  DATA_WIDTH  FIFO head byte; first-word-fall-through, valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_pop  out  1  pop strobe; consumes i_fifo_data at this clock edge. Combinational.
- i_flush  in  1  single-cycle request: drain the FIFO and emit the partial word.
- o_data  out  [0:PACK_LENGTH-1][DATA_WIDTH]  packed word; lane 0 holds the earliest byte.
- o_mask  out  PACK_LENGTH  bit k=1 means lane k is valid.
- o_valid  out  1  word available.
- i_ready  in  1  downstream accepts the word when o_valid & i_ready.
- o_busy  out  1  high when idx≠0, state=HOLD, or flush pending.

Behaviour:
- Reset/clear (i_rst or i_clear high at the clock edge):
  - state=FILL, idx=0, flush_pending=0, o_data=0, o_mask=0, o_valid=0.
  - o_fifo_pop is forced to 0 in that cycle.
  - A word held in HOLD is discarded.
- States:
  - FILL: collecting bytes; o_valid=0.
  - HOLD: word registered; o_valid=1.
- Pop rule: o_fifo_pop = !i_fifo_empty & (state==FILL | (state==HOLD & i_ready)) & !i_rst & !i_clear.
- Each pop:
  - Writes i_fifo_data into lane idx and sets o_mask[idx]. When popping in HOLD, idx is 0, so the byte goes to lane 0 and o_mask becomes 'b1.
  - If idx==PACK_LENGTH-1: idx←0, state←HOLD (word complete; o_valid high the next cycle).
  - Otherwise idx←idx+1 and state←FILL.
- HOLD, i_ready=1:
  - Handshake completes; o_mask clears, except for the bit set by a same-cycle pop.
  - Next state is FILL, or HOLD again if PACK_LENGTH bytes completed (impossible for PACK_LENGTH≥2, hence the parameter minimum).
  - Back-to-back words therefore have no bubble on the pop side.
- HOLD, i_ready=0: o_data, o_mask and o_valid stay stable; no pop.
- Pop-to-o_valid latency: 1 cycle after the pop that completes the word. Full word throughput: PACK_LENGTH cycles per word at full FIFO rate.
- Flush:
  - i_flush sets flush_pending in any state. Setting and resolving in the same cycle is allowed.
  - Flush resolves only in FILL with i_fifo_empty=1:
    - idx>0: state←HOLD, o_valid next cycle, o_mask = low idx bits; unused lanes hold stale data (don't-care). idx←0, flush_pending←0.
    - idx==0: flush_pending←0; no word is emitted.
  - While the FIFO is non-empty, popping continues normally. Full words emitted during a flush do not clear flush_pending.
- Simultaneous i_flush and i_clear: clear wins; flush_pending=0.
- Lane index wraps only via the completion rule; idx never exceeds PACK_LENGTH-1.

Optional Feature:
- Macro: MISO_DRAIN_PACKER_STATS_EN.
- Defined:
  - Extra output o_word_count, 16 bits: counts completed handshakes (full and partial), saturates at 16'hFFFF, and is cleared by i_rst/i_clear.
  - Extra output o_partial_count, 8 bits, saturating: counts partial words only.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package router_pkg holds:
  - default DATA_WIDTH;
  - typedef enum logic {FILL, HOLD} packer_state_t;
  - the saturating counter width constants.
- Single module. No sub-module is warranted; the stats counters are inline under the macro.

Test Plan:
- Reset behaviour: hold i_rst 2 cycles with FIFO non-empty -> o_fifo_pop=0, o_valid=0, o_mask=0, o_busy=0.
- Full word: FIFO supplies A1,B2,C3,D4 with i_ready=1 -> pops on 4 consecutive cycles; o_data={A1,B2,C3,D4} and o_mask=4'b1111 for one cycle starting 1 cycle after the 4th pop.
- Backpressure: 8 bytes 01..08 queued, i_ready=0 -> after 4 pops the pop strobe stops and o_data={01,02,03,04} stays stable. Raising i_ready gives the handshake plus the same-cycle pop of 05; the second word is {05,06,07,08}.
- Partial flush: FIFO supplies 29,18,07 then goes empty; pulse i_flush -> o_valid with o_mask=4'b0111, lanes 0..2 = 29,18,07; o_busy drops after the handshake.
- Flush with no data: i_flush with idx=0 and FIFO empty -> no o_valid, flush_pending clears the next cycle. Flush with 6 queued bytes -> one full word, then one partial word with o_mask=4'b0011.
- Mid-operation clear: i_clear during HOLD with i_ready=0 -> o_valid=0 the next cycle, no pop in the clear cycle; the next bytes land in lane 0.

Source files
------------

// File: rtl/router_pkg.sv
// ============================================================================
//  Module      : router_pkg
//  Description : Shared router types and constants (packer state, counter
//                widths, default byte width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int c_default_data_width  = 8;
    localparam int c_word_count_width    = 16;
    localparam int c_partial_count_width = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

endpackage : router_pkg

`default_nettype wire

// File: rtl/miso_drain_packer.sv
// ============================================================================
//  Module      : miso_drain_packer
//  Description : Drains the router's MISO byte FIFO, packs PACK_LENGTH bytes
//                per word and hands words out over valid/ready; a flush emits
//                the trailing partial word with a lane mask.
//                Optional statistics counters: MISO_DRAIN_PACKER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module miso_drain_packer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = c_default_data_width,
    parameter int PACK_LENGTH = 4,
    parameter int IDX_WIDTH   = $clog2(PACK_LENGTH)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_clear,
    input  logic [DATA_WIDTH-1:0]                 i_fifo_data,
    input  logic                                  i_fifo_empty,
    output logic                                  o_fifo_pop,
    input  logic                                  i_flush,
    output logic [0:PACK_LENGTH-1][DATA_WIDTH-1:0] o_data,
    output logic [PACK_LENGTH-1:0]                o_mask,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_busy
`ifdef MISO_DRAIN_PACKER_STATS_EN
    ,
    output logic [c_word_count_width-1:0]         o_word_count,
    output logic [c_partial_count_width-1:0]      o_partial_count
`endif
);

    localparam logic [IDX_WIDTH-1:0]   c_last_idx = IDX_WIDTH'(PACK_LENGTH - 1);
    localparam logic [PACK_LENGTH-1:0] c_lane0    = PACK_LENGTH'(1);

    packer_state_t                          r_state;
    logic [IDX_WIDTH-1:0]                   r_idx;
    logic                                   r_flush_pending;
    logic [0:PACK_LENGTH-1][DATA_WIDTH-1:0] r_data;
    logic [PACK_LENGTH-1:0]                 r_mask;

    logic                   w_clr;
    logic                   w_hold_accept;
    logic                   w_pop;
    logic                   w_flush_resolve;
    logic [PACK_LENGTH-1:0] w_lane_bit;

    assign w_clr         = i_rst | i_clear;
    assign w_hold_accept = (r_state == HOLD) & i_ready;
    assign w_pop         = ~i_fifo_empty & ((r_state == FILL) | w_hold_accept) & ~w_clr;
    assign w_lane_bit    = c_lane0 << r_idx;

    // A flush raised this cycle may resolve immediately if the FIFO is already dry.
    assign w_flush_resolve = (r_state == FILL) & i_fifo_empty & (r_flush_pending | i_flush);

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state         <= FILL;
            r_idx           <= '0;
            r_flush_pending <= 1'b0;
            r_data          <= '0;
            r_mask          <= '0;
        end else begin
            if (w_pop) begin
                r_data[r_idx] <= i_fifo_data;
                // Popping while handing off a word starts a fresh mask at lane 0.
                r_mask <= w_hold_accept ? w_lane_bit : (r_mask | w_lane_bit);
                if (r_idx == c_last_idx) begin
                    r_idx   <= '0;
                    r_state <= HOLD;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= FILL;
                end
            end else if (w_hold_accept) begin
                r_mask  <= '0;
                r_state <= FILL;
            end else if (w_flush_resolve && (r_idx != '0)) begin
                r_state <= HOLD;
                r_idx   <= '0;
            end

            if (w_flush_resolve) begin
                r_flush_pending <= 1'b0;
            end else if (i_flush) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    assign o_fifo_pop = w_pop;
    assign o_data     = r_data;
    assign o_mask     = r_mask;
    assign o_valid    = (r_state == HOLD);
    assign o_busy     = (r_idx != '0) | (r_state == HOLD) | r_flush_pending;

`ifdef MISO_DRAIN_PACKER_STATS_EN
    logic [c_word_count_width-1:0]    r_word_count;
    logic [c_partial_count_width-1:0] r_partial_count;
    logic                             w_handshake;

    assign w_handshake = w_hold_accept & ~w_clr;

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_word_count    <= '0;
            r_partial_count <= '0;
        end else if (w_handshake) begin
            if (r_word_count != '1) begin
                r_word_count <= r_word_count + 1'b1;
            end
            // A word without every lane set can only come from a flush.
            if ((~&r_mask) && (r_partial_count != '1)) begin
                r_partial_count <= r_partial_count + 1'b1;
            end
        end
    end

    assign o_word_count    = r_word_count;
    assign o_partial_count = r_partial_count;
`endif

endmodule : miso_drain_packer

`default_nettype wire

// File: tb/tb_miso_drain_packer.sv
// ============================================================================
//  Module      : tb_miso_drain_packer
//  Description : Randomized self-checking bench for miso_drain_packer with a
//                byte-stream reference model and word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_miso_drain_packer;

    localparam int DW = 8;
    localparam int PL = 4;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic                    i_clear;
    logic [DW-1:0]           i_fifo_data;
    logic                    i_fifo_empty;
    logic                    o_fifo_pop;
    logic                    i_flush;
    logic [0:PL-1][DW-1:0]   o_data;
    logic [PL-1:0]           o_mask;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_busy;
`ifdef MISO_DRAIN_PACKER_STATS_EN
    logic [15:0]             o_word_count;
    logic [7:0]              o_partial_count;
`endif

    always #5 i_clk = ~i_clk;

    miso_drain_packer #(
        .DATA_WIDTH  (DW),
        .PACK_LENGTH (PL)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_clear),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_pop   (o_fifo_pop),
        .i_flush      (i_flush),
        .o_data       (o_data),
        .o_mask       (o_mask),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy)
`ifdef MISO_DRAIN_PACKER_STATS_EN
        ,
        .o_word_count    (o_word_count),
        .o_partial_count (o_partial_count)
`endif
    );

    logic [7:0]  fifo_q[$];
    logic [7:0]  acc[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_mask[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready = 1'b0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_mask;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < PL; k++) begin
            if (m[k]) r[31-8*k -: 8] = d[31-8*k -: 8];
        end
        return r;
    endfunction

    task automatic update_fifo_if();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    // Reference model: the byte stream is cut into words of PL bytes; a flush
    // closes whatever remainder exists as a masked partial word.
    task automatic push(input logic [7:0] b);
        logic [31:0] w;
        fifo_q.push_back(b);
        acc.push_back(b);
        if (acc.size() == PL) begin
            w = '0;
            for (int k = 0; k < PL; k++) w[31-8*k -: 8] = acc[k];
            exp_data.push_back(w);
            exp_mask.push_back(4'hF);
            acc.delete();
        end
        update_fifo_if();
    endtask

    task automatic model_flush();
        logic [31:0] w;
        logic [3:0]  m;
        if (acc.size() > 0) begin
            w = '0;
            m = '0;
            for (int k = 0; k < acc.size(); k++) begin
                w[31-8*k -: 8] = acc[k];
                m[k] = 1'b1;
            end
            exp_data.push_back(w);
            exp_mask.push_back(m);
            acc.delete();
        end
    endtask

    task automatic monitor();
        logic [31:0] ed;
        logic [3:0]  em;
        bit          clr_now;
        clr_now = i_rst || i_clear;
        if (clr_now) begin
            check_eq("pop_in_clear", o_fifo_pop, 0);
        end else begin
            check_eq("pop_rule", o_fifo_pop && (i_fifo_empty || (o_valid && !i_ready)), 0);
            if (prev_stall) begin
                check_eq("stall_valid", o_valid, 1);
                check_eq("stall_data", o_data, prev_data);
                check_eq("stall_mask", o_mask, prev_mask);
            end
            if (o_valid && i_ready) begin
                if (exp_data.size() == 0) begin
                    check_eq("unexpected_word", 1, 0);
                end else begin
                    ed = exp_data.pop_front();
                    em = exp_mask.pop_front();
                    check_eq("word_mask", o_mask, em);
                    check_eq("word_data", masked(o_data, em), masked(ed, em));
                end
            end
        end
        prev_stall = !clr_now && o_valid && !i_ready;
        prev_data  = o_data;
        prev_mask  = o_mask;
    endtask

    task automatic tick();
        bit pop_now;
        @(negedge i_clk);
        monitor();
        pop_now = o_fifo_pop;
        @(posedge i_clk);
        #1;
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        update_fifo_if();
    endtask

    task automatic pulse_flush();
        i_flush = 1'b1;
        model_flush();
        tick();
        i_flush = 1'b0;
    endtask

    task automatic wait_idle(input bit need_busy_low);
        int t;
        t = 0;
        while (!(fifo_q.size() == 0 && !o_valid && (!need_busy_low || !o_busy)) && t < 300) begin
            tick();
            t++;
        end
        check_eq("idle_wait_expired", (t >= 300), 0);
    endtask

    initial begin
        logic [7:0] cb[8];
        i_rst   = 1'b1;
        i_clear = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        update_fifo_if();

        // Reset with a byte waiting in the FIFO
        push(8'h5A);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            check_eq("rst_pop", o_fifo_pop, 0);
            check_eq("rst_valid", o_valid, 0);
            check_eq("rst_mask", o_mask, 0);
            check_eq("rst_busy", o_busy, 0);
        end
        i_rst = 1'b0;
        tick();
        pulse_flush();
        wait_idle(1);

        // Full word, pop-to-valid latency
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        #1;
        check_eq("fw_pop0", o_fifo_pop, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            check_eq("fw_pop", o_fifo_pop, 1);
        end
        tick();
        #1;
        check_eq("fw_valid", o_valid, 1);
        check_eq("fw_data", o_data, 32'hA1B2C3D4);
        check_eq("fw_mask", o_mask, 4'hF);
        check_eq("fw_pop_after", o_fifo_pop, 0);
        tick();
        #1;
        check_eq("fw_valid_one_cycle", o_valid, 0);

        // Backpressure
        i_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 8; i++) tick();
        #1;
        check_eq("bp_valid", o_valid, 1);
        check_eq("bp_data", o_data, 32'h01020304);
        check_eq("bp_pop_stopped", o_fifo_pop, 0);
        i_ready = 1'b1;
        #1;
        check_eq("bp_same_cycle_pop", o_fifo_pop, 1);
        tick();
        wait_idle(1);

        // Partial flush
        push(8'h29); push(8'h18); push(8'h07);
        tick(); tick(); tick();
        pulse_flush();
        #1;
        check_eq("pf_valid", o_valid, 1);
        check_eq("pf_mask", o_mask, 4'b0111);
        check_eq("pf_data", masked(o_data, 4'b0111), 32'h29180700);
        check_eq("pf_busy", o_busy, 1);
        tick();
        #1;
        check_eq("pf_busy_drop", o_busy, 0);
        check_eq("pf_valid_drop", o_valid, 0);

        // Flush with nothing collected
        pulse_flush();
        #1;
        check_eq("fe_valid", o_valid, 0);
        tick();
        #1;
        check_eq("fe_busy", o_busy, 0);
        check_eq("fe_valid2", o_valid, 0);

        // Flush with six queued bytes: one full word, then mask 0011
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        pulse_flush();
        #1;
        check_eq("f6_busy", o_busy, 1);
        wait_idle(1);

        // Randomized phases
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int n;
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                push(8'($urandom));
                if ($urandom_range(0, 2) == 0) tick();
            end
            tick();
            if (p == 39 || $urandom_range(0, 1) == 1) begin
                pulse_flush();
                wait_idle(1);
            end else begin
                wait_idle(0);
            end
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        tick();

        // Clear while holding a stalled word
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cb[i] = 8'($urandom);
            push(cb[i]);
        end
        for (int i = 0; i < 7; i++) tick();
        #1;
        check_eq("cl_hold_valid", o_valid, 1);
        i_clear = 1'b1;
        #1;
        check_eq("cl_pop_in_clear", o_fifo_pop, 0);
        void'(exp_data.pop_front());
        void'(exp_mask.pop_front());
        tick();
        i_clear = 1'b0;
        #1;
        check_eq("cl_valid", o_valid, 0);
        check_eq("cl_mask", o_mask, 0);
        check_eq("cl_busy", o_busy, 0);
        check_eq("cl_pop_resume", o_fifo_pop, 1);
        tick(); tick(); tick(); tick();
        #1;
        check_eq("cl_lane0", o_data[0], cb[4]);
        i_ready = 1'b1;
        wait_idle(1);

        check_eq("exp_queue_empty", exp_data.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_miso_drain_packer

`default_nettype wire
